// File: rtl/audio_pkg.sv
// Shared definitions for the codec audio path: channel encoding on LRCK,
// capture FSM states and the default channel word width.
package audio_pkg;

    localparam int   AUDIO_WORD_W = 32;
    localparam logic LRCK_LEFT    = 1'b0;
    localparam logic LRCK_RIGHT   = 1'b1;

    typedef enum logic [1:0] {
        WAIT_LEFT = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_adc_receiver_sample_fifo.sv
// Show-ahead FIFO: registered head valid 1 cycle after push; full drops push unless popped same cycle.
// Head register holds its last value when empty; clear wins over push and pop.
module sample_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    input  logic                   i_clear,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [WIDTH-1:0]       o_head_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic             w_push;
    logic [AW-1:0]    w_rd_nxt;
    logic [LW-1:0]    w_remain;
    logic [WIDTH-1:0] w_head_nxt;

    assign o_full     = (r_count == LW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_level    = r_count;
    assign o_head_dat = r_head;

    assign w_pop    = i_pop && !o_empty;
    assign w_push   = i_push && (!o_full || w_pop);
    assign w_rd_nxt = r_rd_ptr + AW'(w_pop);
    assign w_remain = r_count - LW'(w_pop);

    // Next head comes from storage if anything survives the pop, else from the incoming push.
    always_comb begin
        w_head_nxt = r_head;
        if (w_remain != '0) begin
            w_head_nxt = r_mem[w_rd_nxt];
        end else if (w_push) begin
            w_head_nxt = i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_clear && w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= r_count + LW'(w_push) - LW'(w_pop);
            r_head   <= w_head_nxt;
        end
    end

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S ADC capture into stereo pairs; pair visible 1 cycle after the push request that follows the right delay slot.
// No backpressure toward the codec: a full FIFO drops the new pair and sets sticky overflow.
module i2s_adc_receiver
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_WORD_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        AUD_BCLK,
    input  logic                        AUD_ADCLRCK,
    input  logic                        AUD_ADCDAT,
    input  logic                        read_audio_in,
    input  logic                        clear_audio_in_memory,
    output logic                        audio_in_available,
    output logic [DATA_WIDTH-1:0]       left_channel_audio_in,
    output logic [DATA_WIDTH-1:0]       right_channel_audio_in,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [SYNC_STAGES-1:0]  r_bclk_sync;
    logic [SYNC_STAGES-1:0]  r_lrck_sync;
    logic [SYNC_STAGES-1:0]  r_dat_sync;
    logic                    r_bclk_d;
    logic                    r_lrck_prev;
    rx_state_t               r_state;
    logic [DATA_WIDTH-1:0]   r_shreg;
    logic [CW-1:0]           r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_left;
    logic [2*DATA_WIDTH-1:0] r_pair;
    logic                    r_push;
    logic                    r_overflow;

    logic                    w_bclk;
    logic                    w_lrck;
    logic                    w_dat;
    logic                    w_bclk_rise;
    logic                    w_lrck_edge;
    logic                    w_room;
    logic [DATA_WIDTH-1:0]   w_bit_vec;
    logic [DATA_WIDTH-1:0]   w_word_nxt;
    logic [CW-1:0]           w_cnt_nxt;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [2*DATA_WIDTH-1:0] w_head;

    assign w_bclk      = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrck      = r_lrck_sync[SYNC_STAGES-1];
    assign w_dat       = r_dat_sync[SYNC_STAGES-1];
    assign w_bclk_rise = w_bclk && !r_bclk_d;
    assign w_lrck_edge = (w_lrck != r_lrck_prev);

    // Bits land left-aligned by position; once the word is full further bits are ignored.
    assign w_room     = (r_bit_cnt < CW'(DATA_WIDTH));
    assign w_bit_vec  = {w_dat, {(DATA_WIDTH-1){1'b0}}} >> r_bit_cnt;
    assign w_word_nxt = w_room ? (r_shreg | w_bit_vec) : r_shreg;
    assign w_cnt_nxt  = w_room ? (r_bit_cnt + CW'(1)) : r_bit_cnt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_d    <= 1'b0;
        end else begin
            r_bclk_sync <= (r_bclk_sync << 1) | SYNC_STAGES'(AUD_BCLK);
            r_lrck_sync <= (r_lrck_sync << 1) | SYNC_STAGES'(AUD_ADCLRCK);
            r_dat_sync  <= (r_dat_sync << 1) | SYNC_STAGES'(AUD_ADCDAT);
            r_bclk_d    <= w_bclk;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state     <= WAIT_LEFT;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_left      <= '0;
            r_pair      <= '0;
            r_push      <= 1'b0;
            r_lrck_prev <= LRCK_LEFT;
        end else begin
            r_push <= 1'b0;
            if (w_bclk_rise) begin
                r_lrck_prev <= w_lrck;
            end
            if (clear_audio_in_memory) begin
                r_state   <= WAIT_LEFT;
                r_shreg   <= '0;
                r_bit_cnt <= '0;
            end else if (w_bclk_rise) begin
                case (r_state)
                    WAIT_LEFT: begin
                        if (w_lrck_edge && w_lrck == LRCK_LEFT) begin
                            r_state   <= LEFT;
                            r_shreg   <= '0;
                            r_bit_cnt <= '0;
                        end
                    end
                    LEFT: begin
                        if (w_lrck_edge && w_lrck == LRCK_RIGHT) begin
                            r_left    <= w_word_nxt;
                            r_shreg   <= '0;
                            r_bit_cnt <= '0;
                            r_state   <= RIGHT;
                        end else begin
                            r_shreg   <= w_word_nxt;
                            r_bit_cnt <= w_cnt_nxt;
                        end
                    end
                    RIGHT: begin
                        if (w_lrck_edge && w_lrck == LRCK_LEFT) begin
                            r_pair    <= {r_left, w_word_nxt};
                            r_push    <= 1'b1;
                            r_shreg   <= '0;
                            r_bit_cnt <= '0;
                            r_state   <= LEFT;
                        end else begin
                            r_shreg   <= w_word_nxt;
                            r_bit_cnt <= w_cnt_nxt;
                        end
                    end
                    default: r_state <= WAIT_LEFT;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (clear_audio_in_memory) begin
            r_overflow <= 1'b0;
        end else if (r_push && w_fifo_full && !(read_audio_in && !w_fifo_empty)) begin
            r_overflow <= 1'b1;
        end
    end

    sample_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (CLOCK_50),
        .i_rst      (reset),
        .i_push     (r_push),
        .i_push_dat (r_pair),
        .i_pop      (read_audio_in),
        .i_clear    (clear_audio_in_memory),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_level    (fifo_level),
        .o_head_dat (w_head)
    );

    assign audio_in_available     = !w_fifo_empty;
    assign left_channel_audio_in  = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign right_channel_audio_in = w_head[DATA_WIDTH-1:0];
    assign overflow               = r_overflow;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Drives an I2S ADC stream with random words and checks the receiver against a queue-based frame model.
module tb_i2s_adc_receiver;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        AUD_BCLK = 1'b0;
    logic        AUD_ADCLRCK = 1'b1;
    logic        AUD_ADCDAT = 1'b0;
    logic        read_audio_in = 1'b0;
    logic        clear_audio_in_memory = 1'b0;
    logic        audio_in_available;
    logic [31:0] left_channel_audio_in;
    logic [31:0] right_channel_audio_in;
    logic [3:0]  fifo_level;
    logic        overflow;

    always #5 CLOCK_50 = ~CLOCK_50;

    i2s_adc_receiver #(
        .DATA_WIDTH  (32),
        .FIFO_DEPTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .AUD_BCLK               (AUD_BCLK),
        .AUD_ADCLRCK            (AUD_ADCLRCK),
        .AUD_ADCDAT             (AUD_ADCDAT),
        .read_audio_in          (read_audio_in),
        .clear_audio_in_memory  (clear_audio_in_memory),
        .audio_in_available     (audio_in_available),
        .left_channel_audio_in  (left_channel_audio_in),
        .right_channel_audio_in (right_channel_audio_in),
        .fifo_level             (fifo_level),
        .overflow               (overflow)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Model: line-level frame tracking plus a bounded queue of committed pairs.
    logic [63:0] m_q[$];
    logic        m_ovf = 1'b0;
    int          m_stage = 0;
    logic [63:0] m_shown = '0;
    logic [31:0] m_lw = '0;
    logic [31:0] m_rw = '0;
    logic        m_line_prev = 1'b1;
    logic        g_pending = 1'b0;
    logic [31:0] g_slot_exp = '0;
    int          g_rel_idx = -1;
    int          g_rst_idx = -1;

    function automatic void m_sync_head();
        if (m_q.size() > 0) m_shown = m_q[0];
    endfunction

    function automatic void m_push(input logic [63:0] p);
        if (m_q.size() < 8) m_q.push_back(p);
        else m_ovf = 1'b1;
        m_sync_head();
    endfunction

    function automatic void m_pop();
        logic [63:0] dummy;
        if (m_q.size() > 0) dummy = m_q.pop_front();
        m_sync_head();
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_stage = 0;
        m_shown = '0;
    endfunction

    function automatic void m_line(input logic lrck);
        if (!reset && lrck != m_line_prev) begin
            if (lrck == 1'b0) begin
                if (m_stage == 2) m_push({m_lw, m_rw});
                m_stage = 1;
                m_lw = g_slot_exp;
            end else begin
                if (m_stage == 1) m_stage = 2;
                m_rw = g_slot_exp;
            end
        end
        m_line_prev = lrck;
    endfunction

    function automatic logic [31:0] mask_w(input logic [31:0] w, input int width);
        logic [31:0] m;
        m = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return w & m;
    endfunction

    task automatic compare_state(input string tag);
        check_eq({tag, "_avail"}, 64'(audio_in_available), 64'(m_q.size() > 0));
        check_eq({tag, "_level"}, 64'(fifo_level), 64'(m_q.size()));
        check_eq({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        check_eq({tag, "_left"}, 64'(left_channel_audio_in), 64'(m_shown[63:32]));
        check_eq({tag, "_right"}, 64'(right_channel_audio_in), 64'(m_shown[31:0]));
    endtask

    // One BCLK period: 8 cycles low (lines change), 8 cycles high. act acts on the rise:
    // 1 = latency probe, 2 = read in the push cycle, 3 = read + clear in the push cycle.
    task automatic bclk_period(input logic lrck, input logic dat, input int act);
        @(negedge CLOCK_50);
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = lrck;
        AUD_ADCDAT  = dat;
        repeat (8) @(negedge CLOCK_50);
        AUD_BCLK = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLOCK_50);
            if (k == 3) begin
                if (act == 1) check_eq("lat_pre", 64'(audio_in_available), 64'(m_q.size() > 0));
                if (act == 2 || act == 3) read_audio_in = 1'b1;
                if (act == 3) clear_audio_in_memory = 1'b1;
            end
            if (k == 4) begin
                read_audio_in = 1'b0;
                clear_audio_in_memory = 1'b0;
                if (act == 2) m_pop();
                if (act == 3) begin
                    m_q.delete();
                    m_ovf = 1'b0;
                    m_stage = 0;
                    m_line_prev = lrck;
                end else begin
                    m_line(lrck);
                end
                if (act == 1) check_eq("lat_post", 64'(audio_in_available), 64'(m_q.size() > 0));
            end
        end
    endtask

    task automatic send_slot(input logic lrck, input logic [31:0] word, input int width, input int act);
        g_slot_exp = word << (32 - width);
        for (int i = width - 1; i >= 0; i--) begin
            int idx;
            idx = width - 1 - i;
            if (idx == g_rel_idx) begin
                reset = 1'b0;
                g_rel_idx = -1;
            end
            if (idx == g_rst_idx) begin
                @(negedge CLOCK_50);
                reset = 1'b1;
                #1;
                check_eq("arst_avail", 64'(audio_in_available), 64'd0);
                check_eq("arst_left", 64'(left_channel_audio_in), 64'd0);
                check_eq("arst_right", 64'(right_channel_audio_in), 64'd0);
                check_eq("arst_level", 64'(fifo_level), 64'd0);
                check_eq("arst_ovf", 64'(overflow), 64'd0);
                m_reset();
                g_rst_idx = -1;
            end
            bclk_period(lrck, g_pending, (idx == 0) ? act : 0);
            g_pending = word[i];
        end
    endtask

    task automatic send_rl(input logic [31:0] r, input logic [31:0] l, input int width, input int act);
        send_slot(1'b1, mask_w(r, width), width, 0);
        send_slot(1'b0, mask_w(l, width), width, act);
    endtask

    task automatic do_read();
        @(negedge CLOCK_50);
        read_audio_in = 1'b1;
        @(negedge CLOCK_50);
        read_audio_in = 1'b0;
        m_pop();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 16 && m_q.size() > 0; i++) begin
            do_read();
            compare_state(tag);
        end
    endtask

    function automatic int pick_width();
        case ($urandom_range(0, 2))
            0:       return 16;
            1:       return 24;
            default: return 32;
        endcase
    endfunction

    initial begin
        logic [63:0] first_pair;
        m_reset();

        repeat (4) @(negedge CLOCK_50);
        check_eq("rst_avail", 64'(audio_in_available), 64'd0);
        check_eq("rst_left", 64'(left_channel_audio_in), 64'd0);
        check_eq("rst_right", 64'(right_channel_audio_in), 64'd0);
        check_eq("rst_level", 64'(fifo_level), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        send_rl($urandom, 32'hA5A5_0001, 32, 0);
        send_rl(32'h5A5A_8000, $urandom, 32, 1);
        compare_state("t1");
        check_eq("t1_left_val", 64'(left_channel_audio_in), 64'hA5A5_0001);
        check_eq("t1_right_val", 64'(right_channel_audio_in), 64'h5A5A_8000);
        check_eq("t1_level1", 64'(fifo_level), 64'd1);

        @(negedge CLOCK_50);
        reset = 1'b1;
        m_reset();
        repeat (3) @(negedge CLOCK_50);
        g_rel_idx = 10;
        send_rl($urandom, $urandom, 32, 0);
        send_rl($urandom, $urandom, 32, 0);
        compare_state("t2");
        check_eq("t2_level1", 64'(fifo_level), 64'd1);

        drain("t3_pre");
        send_rl($urandom, 32'h0012_3456, 24, 0);
        send_rl($urandom, $urandom, 24, 0);
        compare_state("t3");
        do_read();
        check_eq("t3_short_left", 64'(left_channel_audio_in), 64'h1234_5600);
        compare_state("t3_post");

        drain("t4_pre");
        send_rl($urandom, $urandom, 16, 0);
        first_pair = m_q[0];
        for (int i = 0; i < 8; i++) send_rl($urandom, $urandom, 16, 0);
        compare_state("t4_full");
        check_eq("t4_level8", 64'(fifo_level), 64'd8);
        check_eq("t4_ovf1", 64'(overflow), 64'd1);
        check_eq("t4_head1", {left_channel_audio_in, right_channel_audio_in}, first_pair);
        send_rl($urandom, $urandom, 16, 2);
        compare_state("t4_pushpop");
        check_eq("t4_level_hold", 64'(fifo_level), 64'd8);
        drain("t4_drain");
        do_read();
        compare_state("empty_read");
        check_eq("empty_level", 64'(fifo_level), 64'd0);

        for (int i = 0; i < 5; i++) send_rl($urandom, $urandom, 16, 0);
        check_eq("t5_level5", 64'(fifo_level), 64'd5);
        send_rl($urandom, $urandom, 16, 3);
        compare_state("t5_clear");
        check_eq("t5_ovf0", 64'(overflow), 64'd0);
        send_rl($urandom, $urandom, 16, 0);
        send_rl($urandom, $urandom, 16, 0);
        compare_state("t5_fresh");
        check_eq("t5_level1", 64'(fifo_level), 64'd1);

        for (int i = 0; i < 8; i++) begin
            int nrd;
            send_rl($urandom, $urandom, pick_width(), 0);
            nrd = $urandom_range(0, 2);
            for (int j = 0; j < nrd; j++) do_read();
            compare_state("t6_rand");
        end

        send_rl($urandom, $urandom, 32, 0);
        compare_state("t7_pre");
        g_rst_idx = 5;
        send_slot(1'b1, $urandom, 32, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        compare_state("t7_post");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_adc_receiver.md
Name: i2s_adc_receiver

Overview:
- Capture side of the codec audio path: deserialises the codec ADC I2S stream (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT) into stereo sample pairs in the CLOCK_50 domain.
- Buffers pairs in a small FIFO and presents them through a show-ahead read handshake (audio_in_available / read_audio_in).
- Mirrors the existing playback write handshake (audio_out_allowed / write_audio_out).
- Feeds future record and loop-capture features of the sequencer.

Parameters:
- DATA_WIDTH, 32: bits per channel word, left-aligned in the output.
- FIFO_DEPTH, 8: stereo pairs buffered; must be a power of two, at least 2.
- SYNC_STAGES, 2: synchroniser flops on each codec input.

Ports:
- CLOCK_50  in  1  system clock; all logic is clocked on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- AUD_BCLK  in  1  codec bit clock; asynchronous to CLOCK_50; each phase lasts at least 3 CLOCK_50 cycles.
- AUD_ADCLRCK  in  1  codec ADC word clock: 0 = left channel, 1 = right channel.
- AUD_ADCDAT  in  1  serial ADC data, MSB first.
- read_audio_in  in  1  pop the head pair.
- clear_audio_in_memory  in  1  synchronous flush plus realign.
- audio_in_available  out  1  FIFO is not empty.
- left_channel_audio_in  out  DATA_WIDTH  head-pair left word.
- right_channel_audio_in  out  DATA_WIDTH  head-pair right word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of pairs held.
- overflow  out  1  sticky flag: a pair was dropped because the FIFO was full.

Behaviour:
- Reset values: audio_in_available=0, left and right outputs=0, fifo_level=0, overflow=0. Internal state: FSM in WAIT_LEFT, shift register cleared, synchronisers cleared.
- Synchronisation:
  - All three codec inputs pass through SYNC_STAGES flops.
  - bclk_rise is a one-cycle pulse when the synchronised BCLK goes 0 to 1.
  - Synchronised LRCK and DATA are sampled only on bclk_rise.
- I2S framing:
  - LRCK changes on the falling edge of BCLK.
  - The first BCLK rise that sees a new LRCK value is the delay slot. It still carries the LSB of the previous word, which is shifted in.
  - The MSB of the new word arrives on the following rise.
- Bit counter:
  - Counts shifted bits per word and saturates at DATA_WIDTH; bits beyond DATA_WIDTH are ignored.
  - A short word is left-aligned and zero-padded in the LSBs.
- FSM states:
  - WAIT_LEFT: discard bits until an LRCK 1-to-0 transition is seen on a rise, then go to LEFT. The delay-slot bit is discarded.
  - LEFT: shift bits. On an LRCK 0-to-1 rise, shift in the delay-slot bit, latch the left word, clear the shift register and counter, then go to RIGHT.
  - RIGHT: shift bits. On an LRCK 1-to-0 rise, shift in the delay-slot bit, form the pair {left, right}, issue a push request, then go to LEFT.
- Latency: audio_in_available rises 1 CLOCK_50 cycle after the cycle holding the push request.
- FIFO:
  - Show-ahead: the outputs always show the head entry and hold their last value while empty.
  - A pop on read_audio_in when empty is ignored.
  - Push and pop in the same cycle both take effect, including when full; fifo_level is then unchanged.
  - A push when full with no pop drops the new pair, sets overflow, and leaves the FIFO unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- clear_audio_in_memory takes priority over push and pop in its cycle:
  - empties the FIFO (audio_in_available=0, fifo_level=0, outputs keep their last value);
  - clears overflow;
  - returns the FSM to WAIT_LEFT, discarding any partially captured pair.
- Reset mid-word: all state returns to reset values immediately; capture resumes at the next left-channel start.
- If LRCK toggles with fewer than 1 bit captured, the word is still committed as zero.

Decomposition:
- Shared package audio_pkg:
  - constants LRCK_LEFT=1'b0 and LRCK_RIGHT=1'b1;
  - the FSM state enum (WAIT_LEFT, LEFT, RIGHT);
  - the default audio word width of 32.
- One sub-module, sample_fifo: a synchronous show-ahead FIFO with parameters WIDTH and DEPTH, ports push/pop/clear/full/empty/level. The receiver instantiates it with WIDTH = 2*DATA_WIDTH.

Test Plan:
- Reset and framing: BCLK period 16 cycles (8 high, 8 low), 32-bit slots. Reset, then stream left=0xA5A5_0001 and right=0x5A5A_8000 → exactly one pair appears with those values; audio_in_available is 1 one cycle after the right word's delay slot; fifo_level=1.
- Alignment: release reset mid-right-slot → the partial frame is discarded; the first FIFO entry is the next complete left/right pair.
- Short words: 24-bit slots carrying left=0x123456 → left_channel_audio_in=0x1234_5600.
- Full FIFO: stream 9 pairs with no reads → fifo_level=8, overflow=1, and the head is still pair 1. Then apply read_audio_in coincident with push #10 → level stays 8 and pair 10 is stored.
- Clear: with level=5, pulse clear_audio_in_memory in the same cycle as a push and a read → level=0, overflow=0, FSM in WAIT_LEFT; the next entry is a fresh full pair.
- Empty read and async reset: read_audio_in while empty → nothing changes. Assert reset mid-word → all outputs are 0 in the same cycle.
